// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM state type and counter sizing helper.
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   function automatic int mdu_cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// One-bit-per-cycle datapath: 2*WIDTH shift register with a WIDTH+1
// adder/subtractor doing shift-add multiply or restoring divide.
module mdu_shift_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               div_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opa;
   logic               r_div;

   logic [WIDTH-1:0]   w_hi;
   logic [WIDTH-1:0]   w_lo;
   logic [WIDTH:0]     w_lhs;
   logic [WIDTH:0]     w_rhs;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_acc_nxt;

   assign w_hi  = r_acc[2*WIDTH-1:WIDTH];
   assign w_lo  = r_acc[WIDTH-1:0];
   assign acc_o = r_acc;

   // Divide subtracts via two's complement; sum[WIDTH] set means borrow.
   always_comb begin
      w_lhs = r_div ? {w_hi, w_lo[WIDTH-1]} : {1'b0, w_hi};
      w_rhs = r_div ? ~{1'b0, r_opa} : {1'b0, r_opa};
      w_sum = w_lhs + w_rhs + {{WIDTH{1'b0}}, r_div};
      w_acc_nxt = r_acc;
      if (r_div) begin
         if (!w_sum[WIDTH]) begin
            w_acc_nxt = {w_sum[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = {w_hi[WIDTH-2:0], w_lo, 1'b0};
         end
      end else begin
         if (w_lo[0]) begin
            w_acc_nxt = {w_sum, w_lo[WIDTH-1:1]};
         end else begin
            w_acc_nxt = {1'b0, w_hi, w_lo[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_acc <= '0;
         r_opa <= '0;
         r_div <= 1'b0;
      end else if (load_i) begin
         r_acc <= {{WIDTH{1'b0}}, opb_i};
         r_opa <= opa_i;
         r_div <= div_i;
      end else if (step_i) begin
         r_acc <= w_acc_nxt;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional early termination is enabled by defining MDU_EARLY_OUT_EN.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic             kill_i,
   input  logic [WIDTH-1:0] rs_data_i,
   input  logic [WIDTH-1:0] rt_data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div0_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = mdu_cnt_w(WIDTH);
   localparam logic [CW-1:0] LP_LAST = CW'(WIDTH - 1);

   mdu_state_e r_state;
   mdu_state_e w_state_nxt;

   logic [CW-1:0]    r_count;
   logic             r_is_div;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_dz;
   logic [WIDTH-1:0] r_rs_raw;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;
   logic             r_div0;

   logic             w_accept;
   logic             w_sgn_op;
   logic             w_is_div;
   logic             w_rs_neg;
   logic             w_rt_neg;
   logic             w_dz;
   logic             w_calc_last;
   logic             w_step;
   logic [WIDTH-1:0] w_rs_abs;
   logic [WIDTH-1:0] w_rt_abs;
   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_opb;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic [2*WIDTH-1:0] w_acc;
   logic [2*WIDTH-1:0] w_prod_al;
   logic [2*WIDTH-1:0] w_prod;

   assign w_accept = (r_state == ST_IDLE) && start_i && !kill_i;
   assign w_sgn_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
   assign w_is_div = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
   assign w_rs_neg = w_sgn_op && rs_data_i[WIDTH-1];
   assign w_rt_neg = w_sgn_op && rt_data_i[WIDTH-1];
   assign w_rs_abs = w_rs_neg ? -rs_data_i : rs_data_i;
   assign w_rt_abs = w_rt_neg ? -rt_data_i : rt_data_i;
   assign w_dz     = w_is_div && (rt_data_i == '0);
   assign w_opa    = w_is_div ? w_rt_abs : w_rs_abs;
   assign w_opb    = w_is_div ? w_rs_abs : w_rt_abs;
   assign w_step   = (r_state == ST_CALC) && !kill_i;

   mdu_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (w_accept),
      .step_i (w_step),
      .div_i  (w_is_div),
      .opa_i  (w_opa),
      .opb_i  (w_opb),
      .acc_o  (w_acc)
   );

`ifdef MDU_EARLY_OUT_EN
   logic [WIDTH-1:0] r_mrem;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mrem <= '0;
      end else if (w_accept) begin
         r_mrem <= w_opb;
      end else if (r_state == ST_CALC) begin
         r_mrem <= r_mrem >> 1;
      end
   end

   // A truncated multiply leaves the product high-aligned by WIDTH-count.
   assign w_calc_last = (r_count == LP_LAST) ||
                        (!r_is_div && (r_mrem[WIDTH-1:1] == '0));
   assign w_prod_al   = w_acc >> (CW'(WIDTH) - r_count);
`else
   assign w_calc_last = (r_count == LP_LAST);
   assign w_prod_al   = w_acc;
`endif

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef MDU_EARLY_OUT_EN
               w_state_nxt = w_dz ? ST_FIX : ST_CALC;
`else
               w_state_nxt = ST_CALC;
`endif
            end
         end
         ST_CALC: begin
            if (kill_i) begin
               w_state_nxt = ST_IDLE;
            end else if (w_calc_last) begin
               w_state_nxt = ST_FIX;
            end
         end
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_prod = r_neg_res ? -w_prod_al : w_prod_al;
      w_quo  = r_neg_res ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
      w_rem  = r_neg_rem ? -w_acc[2*WIDTH-1:WIDTH]
                         : w_acc[2*WIDTH-1:WIDTH];
      w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
      w_lo_nxt = w_prod[WIDTH-1:0];
      if (r_dz) begin
         w_hi_nxt = r_rs_raw;
         w_lo_nxt = '1;
      end else if (r_is_div) begin
         w_hi_nxt = w_rem;
         w_lo_nxt = w_quo;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dz      <= 1'b0;
         r_rs_raw  <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_div0    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         if (w_accept) begin
            r_count   <= '0;
            r_is_div  <= w_is_div;
            r_neg_res <= w_rs_neg ^ w_rt_neg;
            r_neg_rem <= w_rs_neg;
            r_dz      <= w_dz;
            r_rs_raw  <= rs_data_i;
         end
         if (r_state == ST_CALC) begin
            r_count <= r_count + CW'(1);
         end
         if ((r_state == ST_FIX) && !kill_i) begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
            r_done <= 1'b1;
            r_div0 <= r_dz;
         end
      end
   end

   assign busy_o = (r_state != ST_IDLE);
   assign done_o = r_done;
   assign div0_o = r_div0;
   assign hi_o   = r_hi;
   assign lo_o   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a result scoreboard.
// Expected latencies follow MDU_EARLY_OUT_EN when it is defined.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int WIDTH = 32;
`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      logic             d0;
      int               cyc;
   } exp_t;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [1:0]       op_i;
   logic             kill_i;
   logic [WIDTH-1:0] rs_data_i;
   logic [WIDTH-1:0] rt_data_i;
   logic             busy_o;
   logic             done_o;
   logic             div0_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   mul_div_unit #(
      .WIDTH (WIDTH)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .op_i      (op_i),
      .kill_i    (kill_i),
      .rs_data_i (rs_data_i),
      .rt_data_i (rt_data_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .div0_o    (div0_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycle of done relative to the start cycle.
   function automatic int exp_cyc(input logic [1:0] op,
                                  input logic [WIDTH-1:0] rt);
      logic [WIDTH-1:0] m;
      int n;
      if (!EARLY) return WIDTH + 2;
      if (op[1]) return (rt == '0) ? 2 : WIDTH + 2;
      m = (op == MDU_MULT && rt[WIDTH-1]) ? -rt : rt;
      n = 1;
      for (int i = 0; i < WIDTH; i++) if (m[i]) n = i + 1;
      return n + 2;
   endfunction

   task automatic push(input logic [WIDTH-1:0] hi,
                       input logic [WIDTH-1:0] lo,
                       input logic d0, input int cyc);
      exp_t e;
      e.hi = hi; e.lo = lo; e.d0 = d0; e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [1:0] op,
                        input logic [WIDTH-1:0] rs,
                        input logic [WIDTH-1:0] rt);
      op_i = op;
      rs_data_i = rs;
      rt_data_i = rt;
      start_i = 1'b1;
   endtask

   // Counts on from cyc until done_o, then pops and compares.
   task automatic wait_done(input string tag, inout int cyc);
      exp_t e;
      bit seen;
      int busy_bad;
      seen = 1'b0;
      busy_bad = 0;
      while (!seen && cyc < 200) begin
         if (done_o) begin
            seen = 1'b1;
         end else begin
            if (!busy_o) busy_bad++;
            tick();
            cyc++;
         end
      end
      chk({tag, " done"}, seen, 1);
      chk({tag, " sb"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, " cycle"}, cyc, e.cyc);
         chk({tag, " busy gaps"}, busy_bad, 0);
         chk({tag, " busy@done"}, busy_o, 0);
         chk({tag, " hi"}, hi_o, e.hi);
         chk({tag, " lo"}, lo_o, e.lo);
         chk({tag, " div0"}, div0_o, e.d0);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [WIDTH-1:0] rs,
                         input logic [WIDTH-1:0] rt,
                         input logic [WIDTH-1:0] ehi,
                         input logic [WIDTH-1:0] elo,
                         input logic ed0);
      int cyc;
      push(ehi, elo, ed0, exp_cyc(op, rt));
      drive(op, rs, rt);
      tick();
      start_i = 1'b0;
      cyc = 1;
      wait_done(tag, cyc);
   endtask

   initial begin
      int cyc;
      int c1;
      int n_done;
      rst_i = 1'b1;
      start_i = 1'b0;
      kill_i = 1'b0;
      op_i = '0;
      rs_data_i = '0;
      rt_data_i = '0;
      tick();
      tick();
      chk("rst busy", busy_o, 0);
      chk("rst done", done_o, 0);
      chk("rst div0", div0_o, 0);
      chk("rst hi", hi_o, 0);
      chk("rst lo", lo_o, 0);
      rst_i = 1'b0;
      tick();

      run_op("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult -3x7", MDU_MULT, -32'sd3, 32'd7,
             32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("mult minxmin", MDU_MULT, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'h0, 1'b0);
      run_op("div -7/2", MDU_DIV, -32'sd7, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0, 32'h8000_0000, 1'b0);
      run_op("divu 5/0", MDU_DIVU, 32'd5, 32'd0,
             32'd5, 32'hFFFF_FFFF, 1'b1);
      run_op("multu 2x3", MDU_MULTU, 32'd2, 32'd3,
             32'd0, 32'd6, 1'b0);

      drive(MDU_DIVU, 32'd100, 32'd7);
      tick();
      start_i = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      chk("kill busy@11", busy_o, 0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o) n_done++;
         tick();
      end
      chk("kill no done", n_done, 0);
      chk("kill hi", hi_o, 0);
      chk("kill lo", lo_o, 6);
      chk("kill div0", div0_o, 0);

      drive(MDU_MULTU, 32'd4, 32'd4);
      kill_i = 1'b1;
      tick();
      start_i = 1'b0;
      kill_i = 1'b0;
      chk("start+kill busy", busy_o, 0);
      tick();

      push(32'd0, 32'd15, 1'b0, exp_cyc(MDU_MULTU, 32'd5));
      drive(MDU_MULTU, 32'd3, 32'd5);
      tick();
      rs_data_i = 32'd7;
      rt_data_i = 32'd11;
      cyc = 1;
      wait_done("b2b first", cyc);
      c1 = exp_cyc(MDU_MULTU, 32'd5);
      push(32'd0, 32'd77, 1'b0, c1 + exp_cyc(MDU_MULTU, 32'd11));
      tick();
      cyc++;
      start_i = 1'b0;
      wait_done("b2b second", cyc);
      tick();

      run_op("div -5/0", MDU_DIV, -32'sd5, 32'd0,
             32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

      drive(MDU_MULTU, 32'd1234, 32'hFFFF_5678);
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_i = 1'b1;
      #1;
      chk("async busy", busy_o, 0);
      chk("async done", done_o, 0);
      chk("async div0", div0_o, 0);
      chk("async hi", hi_o, 0);
      chk("async lo", lo_o, 0);
      tick();
      rst_i = 1'b0;
      tick();

      run_op("multu 9x1", MDU_MULTU, 32'd9, 32'd1,
             32'd0, 32'd9, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
